fitness_eval: RTL and testbench
===============================

// Module: fitness_eval
// PURPOSE
//  Downstream stage of the evolvable logic-element array. Sweeps all 2^IN_W input vectors into
//  the combinational array and reads the array's outputs. Compares each output vector bit-wise
//  against a target truth table held in an external synchronous ROM. Reports the number of
//  matching output bits as the fitness of the loaded chromosome (conf_les/conf_outs).
// PARAMETERS
//  IN_W   8                      array input width; sweep length 2^IN_W vectors
//  OUT_W  8                      array output width; bits scored per vector
//  FIT_W  IN_W+$clog2(OUT_W)+1   fitness width; holds max score 2^IN_W*OUT_W (2048 at defaults)
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request evaluation; sampled only in IDLE
//  abort      in   1      cancel running evaluation
//  busy       out  1      high in RUN/DRAIN; upstream holds chromosome config stable while high
//  done       out  1      one-cycle pulse; fitness/perfect valid from this cycle
//  fitness    out  FIT_W  matching-bit count of last completed evaluation
//  perfect    out  1      fitness == 2^IN_W*OUT_W
//  chrom_in   out  IN_W   stimulus vector to array (chromIn)
//  chrom_out  in   OUT_W  array response (chromOut), combinational from chrom_in
//  exp_addr   out  IN_W   target ROM address
//  exp_data   in   OUT_W  target ROM data, valid 1 cycle after exp_addr
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; busy/done/perfect=0; fitness=0; chrom_in=0;
//   exp_addr=0; accumulator, vector counter, pipeline valid cleared.
//  FSM: IDLE -start-> RUN -vec==2^IN_W-1-> DRAIN -> DONE -> IDLE. abort in RUN/DRAIN -> IDLE.
//  IDLE: chrom_in=exp_addr=0; accumulator cleared when start is accepted.
//  RUN: counter vec = 0..2^IN_W-1, one vector per cycle.
//   chrom_in=exp_addr=vec, both registered outputs.
//   Same cycle: obs_q<=chrom_out, v1<=1.
//  Stage 2 (next cycle): if v1, acc += popcount(~(obs_q ^ exp_data)).
//   Adds 0..OUT_W per vector. acc is FIT_W wide and never overflows.
//  DRAIN: one cycle; final vector accumulates; v1<=0; chrom_in returns to 0.
//  DONE: one cycle. fitness<=acc, perfect<=(acc==MAX), done=1, busy=0.
//  Timing: start sampled high at edge E0 -> busy=1 after E0. done=1 after edge E257 (258 cycles).
//   Back-to-back period with start held high: 259 cycles.
//  start outside IDLE: ignored (no queueing).
//  start and abort both high in IDLE: abort wins, stay IDLE.
//  abort: next state IDLE; no done pulse; fitness/perfect keep previous values; acc discarded.
//  Counter wrap: vec stops at 2^IN_W-1; never wraps to 0 inside RUN.
//  rst_n low mid-run: immediate return to reset values; no done; restart needs new start.
//  fitness/perfect change only at DONE entry or reset.
// STRUCTURE
//  genetico_pkg:
//   - IN_W/OUT_W/FIT_W defaults and FIT_MAX constant.
//   - typedef enum logic [1:0] {IDLE,RUN,DRAIN,DONE} fit_state_t.
//  Sub-module bit_match_count (OUT_W param): combinational popcount of ~(a^b),
//   result $clog2(OUT_W)+1 bits.
//  Top: FSM, vector counter, obs_q/v1 pipeline register, accumulator, output registers.
// TESTING (bench models array and ROM behaviourally)
//  1. Array chrom_out=chrom_in, ROM[v]=v, pulse start -> done 258 cycles later;
//     fitness=2048, perfect=1.
//  2. Array identity, ROM[v]=~v -> fitness=0, perfect=0.
//  3. Array bit0 stuck-at-0, ROM[v]=v -> fitness=1920 (128 mismatches), perfect=0.
//  4. Run 3 done, then start; abort at vec=100; start pulses while busy
//     -> busy=0 next cycle, no done, fitness stays 1920; re-start of case 1 -> 2048.
//  5. rst_n low at vec=50 -> all outputs 0 asynchronously, no done;
//     after release start case 2 -> fitness=0 at 258 cycles.
//  6. start held high across two evaluations -> done pulses exactly 259 cycles apart;
//     exp_addr lags nothing (equals chrom_in) every RUN cycle.

Source files
------------

// File: rtl/genetico_pkg.sv
// Shared constants and state type for the evolvable-array fitness evaluator.
package genetico_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int OUT_W_DEF = 8;
  localparam int FIT_W_DEF = IN_W_DEF + $clog2(OUT_W_DEF) + 1;

  function automatic int fit_max(input int in_w, input int out_w);
    return (1 << in_w) * out_w;
  endfunction

  localparam int FIT_MAX = fit_max(IN_W_DEF, OUT_W_DEF);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fit_state_t;

endpackage

// File: rtl/bit_match_count.sv
// Counts how many bit positions of a and b agree (popcount of the XNOR).
module bit_match_count #(
  parameter int OUT_W = 8,
  localparam int CNT_W = $clog2(OUT_W) + 1
) (
  input  logic [OUT_W-1:0] a,
  input  logic [OUT_W-1:0] b,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (a[i] == b[i]) count = count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fitness_eval.sv
// Sweeps every input vector through the logic-element array and scores the
// responses against the target ROM, reporting matching-bit count as fitness.
module fitness_eval
  import genetico_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int FIT_W = IN_W + $clog2(OUT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [FIT_W-1:0] fitness,
  output logic             perfect,
  output logic [IN_W-1:0]  chrom_in,
  input  logic [OUT_W-1:0] chrom_out,
  output logic [IN_W-1:0]  exp_addr,
  input  logic [OUT_W-1:0] exp_data
);

  localparam int CNT_W = $clog2(OUT_W) + 1;
  localparam logic [FIT_W-1:0] MAX  = FIT_W'(fit_max(IN_W, OUT_W));
  localparam logic [IN_W-1:0]  LAST = '1;

  fit_state_t       state;
  logic [IN_W-1:0]  vec;
  logic [OUT_W-1:0] obs_q;
  logic             v1;
  logic [FIT_W-1:0] acc;
  logic [FIT_W-1:0] acc_next;
  logic [CNT_W-1:0] match_cnt;

  // Array response is captured alongside the ROM read so both arrive together.
  bit_match_count #(.OUT_W(OUT_W)) u_match (
    .a     (obs_q),
    .b     (exp_data),
    .count (match_cnt)
  );

  assign acc_next = v1 ? acc + FIT_W'(match_cnt) : acc;
  assign chrom_in = vec;
  assign exp_addr = vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec     <= '0;
      obs_q   <= '0;
      v1      <= 1'b0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fitness <= '0;
      perfect <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vec  <= '0;
          v1   <= 1'b0;
          done <= 1'b0;
          if (start && !abort) begin
            state <= RUN;
            busy  <= 1'b1;
            acc   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            vec   <= '0;
            v1    <= 1'b0;
            acc   <= '0;
          end else begin
            obs_q <= chrom_out;
            v1    <= 1'b1;
            acc   <= acc_next;
            if (vec == LAST) begin
              state <= DRAIN;
              vec   <= '0;
            end else begin
              vec <= vec + IN_W'(1);
            end
          end
        end
        // Last vector's score lands here, so the result is published straight from acc_next.
        DRAIN: begin
          v1 <= 1'b0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            acc   <= '0;
          end else begin
            acc     <= acc_next;
            fitness <= acc_next;
            perfect <= (acc_next == MAX);
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fitness_eval.sv
// Bench: behavioural array/ROM tables with a popcount reference for fitness.
module tb_fitness_eval;
  import genetico_pkg::*;

  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int FIT_W = IN_W + $clog2(OUT_W) + 1;
  localparam int NV    = 1 << IN_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, perfect;
  logic [FIT_W-1:0] fitness;
  logic [IN_W-1:0]  chrom_in, exp_addr;
  logic [OUT_W-1:0] chrom_out, exp_data;

  logic [OUT_W-1:0] arr_tab [NV];
  logic [OUT_W-1:0] rom_tab [NV];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign chrom_out = arr_tab[chrom_in];
  always @(posedge clk) exp_data <= rom_tab[exp_addr];

  fitness_eval dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .fitness   (fitness),
    .perfect   (perfect),
    .chrom_in  (chrom_in),
    .chrom_out (chrom_out),
    .exp_addr  (exp_addr),
    .exp_data  (exp_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: identity/ROM=v, 1: identity/ROM=~v, 2: bit0 stuck-at-0/ROM=v, 3: random
  task automatic loadTables(input int mode);
    for (int v = 0; v < NV; v++) begin
      case (mode)
        0: begin arr_tab[v] = OUT_W'(v); rom_tab[v] = OUT_W'(v); end
        1: begin arr_tab[v] = OUT_W'(v); rom_tab[v] = ~OUT_W'(v); end
        2: begin arr_tab[v] = OUT_W'(v) & ~OUT_W'(1); rom_tab[v] = OUT_W'(v); end
        default: begin arr_tab[v] = OUT_W'($urandom); rom_tab[v] = OUT_W'($urandom); end
      endcase
    end
  endtask

  function automatic int refFitness();
    int s = 0;
    for (int v = 0; v < NV; v++) s += OUT_W - $countones(arr_tab[v] ^ rom_tab[v]);
    return s;
  endfunction

  task automatic applyStimulus(input string tag, input int exp_fit);
    int k;
    bit seen, seq_ok, busy_ok;
    seen = 0; seq_ok = 1; busy_ok = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checkOutput({tag, "_busy_start"}, busy, 1);
    for (k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      if (!busy) busy_ok = 0;
      if (chrom_in !== ((k <= NV - 1) ? IN_W'(k) : IN_W'(0)) || exp_addr !== chrom_in) seq_ok = 0;
    end
    checkOutput({tag, "_latency"}, seen ? k : 0, 257);
    checkOutput({tag, "_busy_run"}, busy_ok, 1);
    checkOutput({tag, "_sweep"}, seq_ok, 1);
    checkOutput({tag, "_fitness"}, fitness, exp_fit);
    checkOutput({tag, "_perfect"}, perfect, (exp_fit == FIT_MAX) ? 1 : 0);
    checkOutput({tag, "_busy_done"}, busy, 0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int k, d1, d2, dones;
    bit ok;
    loadTables(0);
    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_fitness", fitness, 0);
    checkOutput("rst_chrom_in", chrom_in, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("ident", 2048);
    loadTables(1);
    applyStimulus("inverse", 0);
    loadTables(2);
    applyStimulus("stuck0", 1920);

    // start and abort together in IDLE: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checkOutput("idle_abort_busy", busy, 0);

    // abort mid-run with stray start pulses
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      start = (i == 20 || i == 40) ? 1'b1 : 1'b0;
      if (chrom_in == 100) begin k = i; break; end
    end
    start = 1'b0;
    checkOutput("abort_pos", k, 100);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_vec", chrom_in, 0);
    dones = 0;
    repeat (300) begin @(negedge clk); if (done || busy) dones++; end
    checkOutput("abort_quiet", dones, 0);
    checkOutput("abort_fitness", fitness, 1920);
    checkOutput("abort_perfect", perfect, 0);
    loadTables(0);
    applyStimulus("restart", 2048);

    // asynchronous reset mid-run
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (chrom_in == 50) begin k = i; break; end
    end
    checkOutput("rst_pos", k, 50);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_fitness", fitness, 0);
    checkOutput("arst_perfect", perfect, 0);
    checkOutput("arst_chrom_in", chrom_in, 0);
    checkOutput("arst_exp_addr", exp_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (5) begin @(negedge clk); if (done || busy) dones++; end
    checkOutput("arst_no_restart", dones, 0);
    loadTables(1);
    applyStimulus("after_rst", 0);

    // start held high: back-to-back evaluations
    loadTables(0);
    @(negedge clk); start = 1'b1;
    d1 = -1; d2 = -1; ok = 1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (exp_addr !== chrom_in) ok = 0;
      if (done) begin
        if (d1 < 0) d1 = i;
        else begin d2 = i; break; end
      end
    end
    start = 1'b0;
    checkOutput("b2b_period", (d2 > 0) ? d2 - d1 : 0, 259);
    checkOutput("b2b_addr_eq", ok, 1);
    checkOutput("b2b_fitness", fitness, 2048);
    repeat (3) @(negedge clk);
    checkOutput("b2b_idle", busy, 0);

    // randomized tables against the popcount reference
    for (int r = 0; r < 4; r++) begin
      loadTables(3);
      applyStimulus("rand", refFitness());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
